// File: rtl/dcache_pkg.sv
// dcache_pkg: shared geometry, FSM encoding and address field helpers for dcache_wt.
// Rev 1.0
`default_nettype none

package dcache_pkg;

  localparam int LINES = 16;
  localparam int WORDS = 4;
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_t;

  function automatic logic [TAG_W-1:0] get_tag(input logic [31:0] a);
    return a[31:OFF_W+IDX_W+2];
  endfunction

  function automatic logic [IDX_W-1:0] get_idx(input logic [31:0] a);
    return a[OFF_W+IDX_W+1:OFF_W+2];
  endfunction

  function automatic logic [OFF_W-1:0] get_off(input logic [31:0] a);
    return a[OFF_W+1:2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data storage, combinational read port and synchronous word write.
// Rev 1.0
`default_nettype none

module dcache_array
  import dcache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] idx,
  input  logic [OFF_W-1:0] rd_off,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             we,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [31:0]      wr_data,
  input  logic             set_valid,
  input  logic             clr_valid,
  input  logic [TAG_W-1:0] set_tag
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0]      data [LINES][WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      valid <= '0;
    else if (set_valid)
      valid[idx] <= 1'b1;
    else if (clr_valid)
      valid[idx] <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (we)
      data[idx][wr_off] <= wr_data;
    if (set_valid)
      tags[idx] <= set_tag;
  end

  assign rd_valid = valid[idx];
  assign rd_tag   = tags[idx];
  assign rd_data  = data[idx][rd_off];

endmodule

`default_nettype wire

// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped write-through, no-write-allocate data cache for the MEM stage.
// Rev 1.0
`default_nettype none

module dcache_wt
  import dcache_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  state_t           state, state_nxt;
  logic [OFF_W-1:0] cnt;
  logic [TAG_W-1:0] lat_tag;
  logic [IDX_W-1:0] lat_idx;
  logic [OFF_W-1:0] lat_off;
  logic [31:0]      lat_data;
  logic             done;

  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] rd_off, wr_off;
  logic [TAG_W-1:0] cmp_tag, rd_tag;
  logic             rd_valid, hit;
  logic [31:0]      rd_data, wr_data;
  logic             we, set_valid, clr_valid;
  logic             start_wr, start_rd;
  logic             unused_addr;

  assign unused_addr = &{1'b0, addr_i[1:0]};

  // In IDLE the array is looked up with the live address; otherwise with the latched one.
  assign idx     = (state == IDLE) ? get_idx(addr_i) : lat_idx;
  assign rd_off  = (state == IDLE) ? get_off(addr_i) : lat_off;
  assign cmp_tag = (state == IDLE) ? get_tag(addr_i) : lat_tag;
  assign hit     = rd_valid && (rd_tag == cmp_tag);

  assign start_wr = (state == IDLE) && MemWrite_i && !done;
  assign start_rd = (state == IDLE) && MemRead_i && !MemWrite_i && !hit;

  dcache_array u_array (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .idx       (idx),
    .rd_off    (rd_off),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .we        (we),
    .wr_off    (wr_off),
    .wr_data   (wr_data),
    .set_valid (set_valid),
    .clr_valid (clr_valid),
    .set_tag   (lat_tag)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      done     <= 1'b0;
      lat_tag  <= '0;
      lat_idx  <= '0;
      lat_off  <= '0;
      lat_data <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == WRITE) && mem_ack_i;
      if (start_wr) begin
        lat_tag  <= get_tag(addr_i);
        lat_idx  <= get_idx(addr_i);
        lat_off  <= get_off(addr_i);
        lat_data <= data_i;
      end else if (start_rd) begin
        lat_tag <= get_tag(addr_i);
        lat_idx <= get_idx(addr_i);
        cnt     <= '0;
      end else if (state == REFILL && mem_ack_i) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    data_o      = '0;
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    we          = 1'b0;
    wr_off      = '0;
    wr_data     = '0;
    set_valid   = 1'b0;
    clr_valid   = 1'b0;
    case (state)
      IDLE: begin
        if (start_wr) begin
          stall_o   = 1'b1;
          state_nxt = WRITE;
        end else if (start_rd) begin
          // Drop the old line now so a half-filled line can never look valid.
          stall_o   = 1'b1;
          clr_valid = 1'b1;
          state_nxt = REFILL;
        end else if (MemRead_i && !MemWrite_i) begin
          data_o = rd_data;
        end
      end
      REFILL: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {lat_tag, lat_idx, cnt, 2'b00};
        if (mem_ack_i) begin
          we      = 1'b1;
          wr_off  = cnt;
          wr_data = mem_rdata_i;
          if (cnt == OFF_W'(WORDS - 1)) begin
            set_valid = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      WRITE: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {lat_tag, lat_idx, lat_off, 2'b00};
        mem_wdata_o = lat_data;
        if (mem_ack_i) begin
          we        = hit;
          wr_off    = lat_off;
          wr_data   = lat_data;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_i) begin
      data_o    = '0;
      stall_o   = 1'b0;
      mem_req_o = 1'b0;
      mem_we_o  = 1'b0;
      we        = 1'b0;
      set_valid = 1'b0;
      clr_valid = 1'b0;
    end
  end

endmodule

`default_nettype wire
